alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter BW, 16, operand/result bitwidth; SHALL support any BW >= 4.
REQ-002 clk  input  1  rising-edge clock; only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand/opcode valid.
REQ-005 in_ready  output  1  block accepts an operation; accept = in_valid && in_ready.
REQ-006 in_a  input  BW  signed operand A.
REQ-007 in_b  input  BW  signed operand B; shift amount = in_b[$clog2(BW)-1:0].
REQ-008 opcode  input  4  operation select.
REQ-009 sat_en  input  1  saturate ADD/SUB/INC/MUL on overflow.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result; handshake = out_valid && out_ready.
REQ-012 out  output  BW  signed result, registered.
REQ-013 flags  output  4  {carry, overflow, negative, zero}, registered.

Function
REQ-014 in_a, in_b, opcode and sat_en SHALL be captured on accept; later input changes SHALL NOT affect the result.
REQ-015 Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 INC (a+1), 0110 PASS A, 0111 PASS B, 1000 MUL (signed, low BW bits), 1001 SHL (logical), 1010 SRA (arithmetic right); 1011-1111 reserved.
REQ-016 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) && !rst; out_valid = (state==DONE).
REQ-017 IDLE: accept of non-MUL op -> DONE next cycle (out_valid 1 cycle after accept); accept of MUL -> BUSY.
REQ-018 BUSY: exactly BW cycles, then DONE; out_valid asserts BW+1 cycles after accept cycle; in_valid ignored.
REQ-019 DONE: out and flags held stable while out_ready low; out_ready high -> IDLE next cycle; no new accept in the handshake cycle.
REQ-020 ADD/SUB/INC overflow: two's-complement signed overflow (ADD: same-sign operands, result sign differs; SUB: opposite-sign operands, result sign differs from a; INC: a == max positive).
REQ-021 carry: ADD/INC unsigned carry-out of bit BW-1; SUB borrow (unsigned a < b); 0 for all other ops.
REQ-022 MUL overflow: full 2*BW-bit signed product bits [2BW-1:BW-1] not all equal.
REQ-023 sat_en=1 and overflow=1: out = max positive (0x7FFF for BW=16) if true result positive, min negative (0x8000) if negative; overflow flag stays 1.
REQ-024 Logic, PASS, shift ops: carry=0, overflow=0; SHL/SRA shift by 0 returns in_a.
REQ-025 negative = out[BW-1], zero = (out==0), both evaluated on final (post-saturation) out.
REQ-026 Reserved opcodes: out=0, flags=0001, latency 1 cycle.

Reset
REQ-027 With rst high at a rising edge: state=IDLE, out=0, flags=0000, out_valid=0, any MUL in progress discarded.
REQ-028 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-029 Reset SHALL take priority over any simultaneous accept or output handshake.

Verification (BW=16)
REQ-030 ADD 0x7FFF+0x0001, sat_en=0 -> 1 cycle later out=0x8000, flags=0110; same with sat_en=1 -> out=0x7FFF, flags=0100.
REQ-031 SUB 0x0003-0x0005 -> out=0xFFFE, flags=1010; INC 0xFFFF -> out=0x0000, flags=1001.
REQ-032 MUL 0xFFFD*0x0007 -> out=0xFFEB, flags=0010, out_valid exactly 17 cycles after accept, in_ready 0 throughout; MUL 0x0100*0x0100 sat_en=1 -> out=0x7FFF, flags=0100.
REQ-033 SRA 0x8000 by 15 -> 0xFFFF, flags=0010; SHL 0x0001 by 15 -> 0x8000, flags=0010.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out/flags constant, in_ready 0, no accept; release -> IDLE next cycle, in_ready 1.
REQ-035 Assert rst in 8th BUSY cycle of a MUL -> next cycle out_valid=0, out=0x0000, flags=0000; in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc -- multi-cycle signed ALU with valid/ready handshakes.
//
// Single-cycle operations (add, sub, logic, inc, pass, shifts, reserved)
// produce their result one cycle after accept. Signed multiply occupies the
// block for BW busy cycles before the result is presented. The result and
// flags are held in DONE until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request valid
//   in_ready   block can accept (IDLE and not in reset)
//   in_a       signed operand A
//   in_b       signed operand B; low $clog2(BW) bits are the shift amount
//   opcode     operation select
//   sat_en     saturate ADD/SUB/INC/MUL on signed overflow
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   out        registered signed result
//   flags      registered {carry, overflow, negative, zero}
// ----------------------------------------------------------------------------
module alu_mc #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  input  logic          sat_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [3:0]    flags
);

  localparam int SW = $clog2(BW);
  localparam int CW = $clog2(BW + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_PASA = 4'b0110;
  localparam logic [3:0] OP_PASB = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  localparam logic [BW-1:0] MAX_POS = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] MIN_NEG = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   a_q, b_q;
  logic            sat_q;
  logic [BW-1:0]   out_q, out_d;
  logic [3:0]      flags_q, flags_d;
  logic            accept_s;

  // Pack {carry, overflow, negative, zero} with the final result.
  function automatic logic [BW+3:0] pack_f(input logic c, input logic v,
                                           input logic [BW-1:0] r);
    return {c, v, r[BW-1], (r == {BW{1'b0}}), r};
  endfunction

  // Single-cycle operations. On saturation the true result sign equals the
  // sign of a, since overflow only occurs when the exact result leaves the
  // range on a's side.
  function automatic logic [BW+3:0] alu_f(input logic [BW-1:0] a,
                                          input logic [BW-1:0] b,
                                          input logic [3:0]    op,
                                          input logic          sat);
    logic [BW:0]   ext;
    logic [BW-1:0] r;
    logic          c;
    logic          v;
    ext = {(BW+1){1'b0}};
    r   = {BW{1'b0}};
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[BW-1:0];
        c   = ext[BW];
        v   = (a[BW-1] == b[BW-1]) && (r[BW-1] != a[BW-1]);
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[BW-1:0];
        c   = ext[BW];
        v   = (a[BW-1] != b[BW-1]) && (r[BW-1] != a[BW-1]);
      end
      OP_INC: begin
        ext = {1'b0, a} + {{BW{1'b0}}, 1'b1};
        r   = ext[BW-1:0];
        c   = ext[BW];
        v   = (a == MAX_POS);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_PASA: r = a;
      OP_PASB: r = b;
      OP_SHL:  r = a << b[SW-1:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[SW-1:0]);
      default: r = {BW{1'b0}};
    endcase
    if (v && sat) begin
      r = a[BW-1] ? MIN_NEG : MAX_POS;
    end else begin
      r = r;
    end
    return pack_f(c, v, r);
  endfunction

  // Signed multiply, low BW bits; overflow when the upper product bits are
  // not a pure sign extension of bit BW-1.
  function automatic logic [BW+3:0] mul_f(input logic [BW-1:0] a,
                                          input logic [BW-1:0] b,
                                          input logic          sat);
    logic signed [2*BW-1:0] p;
    logic [BW-1:0]          r;
    logic                   v;
    p = $signed(a) * $signed(b);
    v = !((p[2*BW-1:BW-1] == {(BW+1){1'b0}}) ||
          (p[2*BW-1:BW-1] == {(BW+1){1'b1}}));
    if (v && sat) begin
      r = p[2*BW-1] ? MIN_NEG : MAX_POS;
    end else begin
      r = p[BW-1:0];
    end
    return pack_f(1'b0, v, r);
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;
  assign accept_s  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, busy counter and result computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            state_d = BUSY;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d          = DONE;
            {flags_d, out_d} = alu_f(in_a, in_b, opcode, sat_en);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(BW - 1)) begin
          state_d          = DONE;
          {flags_d, out_d} = mul_f(a_q, b_q, sat_q);
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: captured operands, busy counter, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= {BW{1'b0}};
      b_q     <= {BW{1'b0}};
      sat_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      out_q   <= {BW{1'b0}};
      flags_q <= 4'b0000;
    end else begin
      if (accept_s) begin
        a_q   <= in_a;
        b_q   <= in_b;
        sat_q <= sat_en;
      end
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  opcode;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  alu_mc #(.BW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .opcode    (opcode),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: exact integer arithmetic, then wrap/saturate to 16 bits.
  function automatic logic [19:0] ref_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input bit s);
    longint sa, sb, ua, ub, tr;
    int     sh;
    bit     ar, c, v;
    logic [15:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b[3:0]);
    ar = 1'b0; c = 1'b0; v = 1'b0; tr = 0; r = 16'h0000;
    case (op)
      4'd0: begin tr = sa + sb; c = (ua + ub) > 65535; ar = 1'b1; end
      4'd1: begin tr = sa - sb; c = ua < ub;           ar = 1'b1; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin tr = sa + 1;  c = (ua + 1) > 65535;  ar = 1'b1; end
      4'd6: r = a;
      4'd7: r = b;
      4'd8: begin tr = sa * sb; ar = 1'b1; end
      4'd9: begin tr = ua * (longint'(1) << sh); r = tr[15:0]; end
      4'd10: begin tr = sa >>> sh; r = tr[15:0]; end
      default: r = 16'h0000;
    endcase
    if (ar) begin
      v = (tr > 32767) || (tr < -32768);
      r = tr[15:0];
      if (v && s) r = (tr > 0) ? 16'h7FFF : 16'h8000;
    end
    return {c, v, r[15], (r == 16'h0000), r};
  endfunction

  // Issue one operation from an IDLE negedge, check latency/result/hold,
  // then complete the output handshake and return at an IDLE negedge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input bit s, input int hold);
    logic [19:0] exp;
    int          lat, n;
    logic [15:0] o_snap;
    logic [3:0]  f_snap;
    exp = ref_f(a, b, op, s);
    lat = (op == 4'd8) ? 17 : 1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; opcode = op; sat_en = s;
    @(posedge clk);
    #1;
    // Disturb inputs after accept; they must not affect the result.
    in_a = 16'($urandom); in_b = 16'($urandom);
    opcode = 4'($urandom); sat_en = 1'($urandom);
    in_valid = 1'($urandom);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      in_valid = 1'($urandom);
    end
    chk("latency", n, lat);
    chk("out", {16'd0, out}, {16'd0, exp[15:0]});
    chk("flags", {28'd0, flags}, {28'd0, exp[19:16]});
    o_snap = out; f_snap = flags;
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out", {12'd0, f_snap, o_snap}, {12'd0, flags, out});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 16'h1234; in_b = 16'h0001; opcode = 4'd0; sat_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // Directed corner vectors.
    run_op(16'h7FFF, 16'h0001, 4'd0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 4'd0, 1'b1, 0);
    run_op(16'h0003, 16'h0005, 4'd1, 1'b0, 1);
    run_op(16'hFFFF, 16'h0000, 4'd5, 1'b0, 0);
    run_op(16'hFFFD, 16'h0007, 4'd8, 1'b0, 0);
    run_op(16'h0100, 16'h0100, 4'd8, 1'b1, 0);
    run_op(16'h8000, 16'h000F, 4'd10, 1'b0, 0);
    run_op(16'h0001, 16'h000F, 4'd9, 1'b0, 0);
    run_op(16'hA5A5, 16'h0010, 4'd9, 1'b0, 0);
    run_op(16'h8001, 16'h0000, 4'd10, 1'b0, 0);
    run_op(16'h7FFF, 16'h0000, 4'd5, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 4'd1, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 4'd0, 1'b1, 0);
    run_op(16'h1234, 16'h5678, 4'd12, 1'b1, 0);
    run_op(16'h5555, 16'hAAAA, 4'd3, 1'b0, 5);

    // Reset during the 8th busy cycle of a multiply.
    in_valid = 1'b1; in_a = 16'h0123; in_b = 16'h0045; opcode = 4'd8; sat_en = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out", {16'd0, out}, 32'd0);
    chk("mrst_flags", {28'd0, flags}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_release_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mrst_discarded", {31'd0, out_valid}, 32'd0);
    end

    // Randomized operations with occasional corner operands.
    for (int k = 0; k < 300; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        default: ra = ra;
      endcase
      if (($urandom_range(0, 3) == 0) && (rop == 4'd8)) begin
        ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      end
      run_op(ra, rb, rop, 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
